muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Multi-cycle multiply/divide controller for the pipelined MIPS core. It owns the HI/LO register pair. It sequences a shared iterative datapath: shift-add for MULT/MULTU, restoring division for DIV/DIVU. It sits beside the execute stage and raises a stall to the hazard logic whenever a HI/LO consumer or a new mult/div instruction arrives while an operation is in flight.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- start  in  1  mult/div instruction in execute, sampled only in IDLE
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- srca, srcb  in  WIDTH  multiplicand/dividend, multiplier/divisor
- rd_req  in  1  mfhi/mflo in decode
- wr_hi, wr_lo  in  1  mthi/mtlo in execute
- wdata  in  WIDTH  mthi/mtlo data
- busy  out  1  state != IDLE
- stall  out  1  busy & (rd_req | start | wr_hi | wr_lo), combinational
- done  out  1  one-cycle pulse, result valid in HI/LO
- dbz  out  1  last division had divisor 0
- hi, lo  out  WIDTH  architectural HI/LO

## Operation
- Reset values: state IDLE, hi=0, lo=0, done=0, dbz=0, busy=0, iteration counter=0.
- States:
  - IDLE: on start, latch |srca|, |srcb|, negate flags, and op; clear dbz; load counter with WIDTH-1; go to RUN. Signed magnitudes apply only for MULT/DIV.
  - RUN: one shift-add or shift-subtract-restore step per cycle; counter decrements; at counter==0 go to FIX.
  - FIX: apply sign correction, write hi/lo, assert done on next cycle, go to IDLE.
- MULT: product negated (2·WIDTH-bit two's complement) when operand signs differ; hi=upper, lo=lower.
- DIV: quotient negated when signs differ; remainder takes sign of dividend; lo=quotient, hi=remainder.
- MIN/-1 (signed): lo=0x80000000, hi=0, no exception.
- Divisor 0 (DIVU/DIV): detected in IDLE. Same latency is kept. Result lo=all-ones, hi=srca unmodified, dbz=1. dbz holds until next accepted start.
- mthi/mtlo in IDLE: hi/lo written at next edge; both asserted writes both.
- start together with wr_hi/wr_lo in IDLE: start wins, write dropped (cannot occur in single-issue flow).
- Any start/wr while busy: ignored by this block; stall holds the instruction upstream until IDLE.
- reset mid-operation: immediate return to IDLE with reset values; the partial result is discarded.

## Timing
- Accept edge E0 (start=1 in IDLE).
- busy=1 for exactly WIDTH+1 cycles after E0: WIDTH RUN cycles, 1 FIX cycle.
- hi/lo updated at edge E0+WIDTH+1.
- done=1 for the cycle following that edge, with busy=0.
- rd_req during the done cycle does not stall and reads the new value.
- A new start in the done cycle is accepted; back-to-back issue throughput is WIDTH+2 cycles per op.
- stall is purely combinational from busy and requests; no added latency.
- mthi/mtlo latency: 1 edge.

## Structure
- Shared package muldiv_pkg:
  - op encodings OP_MULTU/OP_MULT/OP_DIVU/OP_DIV
  - state enum IDLE/RUN/FIX
  - counter width $clog2(WIDTH)
- Sub-module cond_neg (parameter WIDTH): output = neg ? -in : in.
  - Used for operand abs.
  - Used for product, quotient and remainder correction.
- Datapath (2·WIDTH accumulator, divisor/multiplicand register) and FSM live in muldiv_sequencer.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done pulse once.
- MULT -3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 → lo=14, hi=2; DIV 0x80000000 / -1 → lo=0x80000000, hi=0.
- DIVU 0x1234 / 0 → lo=0xFFFFFFFF, hi=0x1234, dbz=1 after 33 cycles; next MULTU clears dbz at accept.
- rd_req held from E0+1 → stall=1 for all 33 busy cycles, 0 in done cycle. mthi 0xABCD while busy → ignored, stall=1. mthi 0xABCD in IDLE → hi=0xABCD next edge.
- reset asserted at E0+10 of a DIV → hi=lo=0, busy=0 immediately. New start after deassert completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: op codes, FSM states
// and the iteration-counter width helper.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

  // Counter must hold WIDTH-1; guarded so a 1-bit build still gets a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_cond_neg.sv
// Conditional two's-complement negation, used both to take operand magnitudes
// and to restore the sign of product, quotient and remainder.
module cond_neg #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + {{(WIDTH-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner for the MIPS core: sequences an iterative shift-add multiplier and
// restoring divider, one step per cycle, and stalls conflicting HI/LO users.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             rd_req,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);

  state_t state, state_next;

  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;
  logic [WIDTH-1:0]     raw_a;
  logic                 is_div;
  logic                 neg_hl;
  logic                 neg_rem;
  logic                 div_zero;

  logic                 sign_a, sign_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH:0]     div_ext;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fixed;
  logic [WIDTH-1:0]     quot_fixed;
  logic [WIDTH-1:0]     rem_fixed;

  // Only the signed ops (op[0] set) take magnitudes.
  assign sign_a = op[0] & srca[WIDTH-1];
  assign sign_b = op[0] & srcb[WIDTH-1];

  cond_neg #(.WIDTH(WIDTH)) u_abs_a (.neg(sign_a), .din(srca), .dout(mag_a));
  cond_neg #(.WIDTH(WIDTH)) u_abs_b (.neg(sign_b), .din(srcb), .dout(mag_b));

  // Multiply step: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide step: acc = {partial remainder, dividend bits / quotient bits}.
  // The shifted remainder needs one extra bit, so the trial subtract is WIDTH+1 wide.
  assign div_ext  = {acc, 1'b0};
  assign div_diff = div_ext[2*WIDTH:WIDTH] - {1'b0, opnd};
  assign div_next = div_diff[WIDTH] ? div_ext[2*WIDTH-1:0]
                                    : {div_diff[WIDTH-1:0], div_ext[WIDTH-1:1], 1'b1};

  cond_neg #(.WIDTH(2*WIDTH)) u_fix_p (.neg(neg_hl),  .din(acc),                    .dout(prod_fixed));
  cond_neg #(.WIDTH(WIDTH))   u_fix_q (.neg(neg_hl),  .din(acc[WIDTH-1:0]),         .dout(quot_fixed));
  cond_neg #(.WIDTH(WIDTH))   u_fix_r (.neg(neg_rem), .din(acc[2*WIDTH-1:WIDTH]),   .dout(rem_fixed));

  assign busy  = (state != IDLE);
  assign stall = busy & (rd_req | start | wr_hi | wr_lo);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      raw_a    <= '0;
      is_div   <= 1'b0;
      neg_hl   <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Divider keeps the dividend in acc; multiplier keeps the multiplier there.
            acc      <= op[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
            opnd     <= op[1] ? mag_b : mag_a;
            raw_a    <= srca;
            is_div   <= op[1];
            neg_hl   <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            div_zero <= op[1] & (srcb == '0);
            dbz      <= 1'b0;
            cnt      <= CW'(WIDTH-1);
          end else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
          end
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          dbz  <= div_zero;
          if (div_zero) begin
            hi <= raw_a;
            lo <= '1;
          end else if (is_div) begin
            hi <= rem_fixed;
            lo <= quot_fixed;
          end else begin
            hi <= prod_fixed[2*WIDTH-1:WIDTH];
            lo <= prod_fixed[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
